// File: rtl/pika_pkg.sv
// Shared definitions for the instruction-fetch slice.
// Holds the datapath word width, the default reset PC and the fetch
// controller state encoding so every file agrees on them.
package pika_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

  // BOOT  : single settle cycle after reset release, no request issued
  // FETCH : normal fetching into the decode holding slot
  // FLUSH : a redirect arrived while a request was outstanding; the
  //         request is kept alive until acked, its data is dropped
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage.
// Owns the PC, issues instruction-memory requests, and holds one fetched
// instruction for decode. Branch redirects from execute flush the held
// instruction; a redirect that lands while a request is outstanding is
// parked in a redirect register until the memory acks the old request.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - asynchronous, active-low reset
//   imem_req   - instruction-memory request
//   imem_addr  - fetch address (the PC)
//   imem_ack   - memory response valid (may coincide with the request)
//   imem_data  - instruction word, valid with imem_ack
//   br_taken   - redirect request from execute
//   br_target  - redirect PC, valid with br_taken
//   stall      - decode cannot accept the held instruction
//   id_valid   - id_instr/id_pc hold a valid instruction
//   id_instr   - instruction passed to decode
//   id_pc      - address of id_instr
//   if_pc_in   - current PC for the register-file PC write port
module fetch_stage
  import pika_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_INC   = 32'd1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        stall,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] if_pc_in
);

  fetch_state_t state;
  word_t        pc;
  word_t        redirect;
  logic         slot_free;

  // The holding slot can take a new instruction when it is empty or is
  // being consumed this cycle. A request issued under this rule cannot be
  // withdrawn before its ack: while it waits no capture happens, so the
  // slot only drains and slot_free stays true.
  assign slot_free = !id_valid || !stall;
  assign imem_req  = ((state == ST_FETCH) && slot_free) || (state == ST_FLUSH);
  assign imem_addr = pc;
  assign if_pc_in  = pc;

  // A redirect always wins over capture and stall. If it arrives while a
  // request is still waiting for its ack, the PC (and thus imem_addr) must
  // not move, so the target is parked and FLUSH waits out the old request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_BOOT;
      pc       <= RESET_PC;
      redirect <= '0;
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
    end else begin
      case (state)
        ST_BOOT: begin
          id_valid <= 1'b0;
          state    <= ST_FETCH;
        end

        ST_FETCH: begin
          if (br_taken) begin
            id_valid <= 1'b0;
            if (imem_req && !imem_ack) begin
              redirect <= br_target;
              state    <= ST_FLUSH;
            end else begin
              pc <= br_target;
            end
          end else if (imem_req && imem_ack) begin
            id_valid <= 1'b1;
            id_instr <= imem_data;
            id_pc    <= pc;
            pc       <= pc + PC_INC;
          end else if (id_valid && !stall) begin
            id_valid <= 1'b0;
          end
        end

        ST_FLUSH: begin
          id_valid <= 1'b0;
          if (br_taken) begin
            redirect <= br_target;
          end
          // The newest redirect wins, even one arriving with the ack.
          if (imem_ack) begin
            pc    <= br_taken ? br_target : redirect;
            state <= ST_FETCH;
          end
        end

        default: begin
          state <= ST_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage.
// A behavioural model of the fetch rules (PC, holding slot, pending
// redirect) predicts every output each cycle; directed sequences with
// hand-computed literals pin the model, then a long randomized run
// exercises stalls, delayed acks, redirects and a mid-run reset.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        br_taken;
  logic [31:0] br_target;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] if_pc_in;

  int total;
  int bad;

  // Behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_redirect;
  bit          m_boot;
  bit          m_flushing;
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_idpc;

  // Request-stability tracking from the previous cycle
  bit          pend;
  logic [31:0] pend_addr;

  fetch_stage dut (
    .clk       (clk),
    .reset     (reset),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .br_taken  (br_taken),
    .br_target (br_target),
    .stall     (stall),
    .id_valid  (id_valid),
    .id_instr  (id_instr),
    .id_pc     (id_pc),
    .if_pc_in  (if_pc_in)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, report it when it fails.
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_pc       = 32'h0;
    m_redirect = 32'h0;
    m_boot     = 1'b1;
    m_flushing = 1'b0;
    m_valid    = 1'b0;
    m_instr    = 32'h0;
    m_idpc     = 32'h0;
    pend       = 1'b0;
    pend_addr  = 32'h0;
  endtask

  // The request the fetch rules call for in the current cycle.
  function automatic bit modelReq();
    if (m_boot) return 1'b0;
    if (m_flushing) return 1'b1;
    return !(m_valid && stall);
  endfunction

  // Compare every meaningful DUT output against the model, plus the
  // rule that an unacked request must hold its address.
  task automatic checkOutput();
    bit exp_req;
    exp_req = modelReq();
    chk("imem_req", {31'h0, imem_req}, {31'h0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("if_pc_in", if_pc_in, m_pc);
    chk("id_valid", {31'h0, id_valid}, {31'h0, m_valid});
    if (m_valid) begin
      chk("id_pc", id_pc, m_idpc);
      chk("id_instr", id_instr, m_instr);
    end
    if (pend) begin
      chk("req_stable", {31'h0, imem_req}, 32'h1);
      chk("addr_stable", imem_addr, pend_addr);
    end
    pend      = imem_req && !imem_ack;
    pend_addr = imem_addr;
  endtask

  // Advance the model across one rising edge using the inputs held there.
  task automatic clockModel();
    bit req;
    @(posedge clk);
    req = modelReq();
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_flushing) begin
      m_valid = 1'b0;
      if (br_taken) m_redirect = br_target;
      if (imem_ack) begin
        m_pc       = m_redirect;
        m_flushing = 1'b0;
      end
    end else if (br_taken) begin
      m_valid = 1'b0;
      if (req && !imem_ack) begin
        m_redirect = br_target;
        m_flushing = 1'b1;
      end else begin
        m_pc = br_target;
      end
    end else if (req && imem_ack) begin
      m_valid = 1'b1;
      m_instr = imem_data;
      m_idpc  = m_pc;
      m_pc    = m_pc + 32'd1;
    end else if (m_valid && !stall) begin
      m_valid = 1'b0;
    end
  endtask

  // Drive one cycle of inputs half a period before the edge, then check.
  task automatic applyStimulus(input bit s, input bit a, input bit b,
                               input logic [31:0] t, input logic [31:0] d);
    @(negedge clk);
    stall     = s;
    imem_ack  = a;
    br_taken  = b;
    br_target = t;
    imem_data = d;
    #1;
    checkOutput();
  endtask

  task automatic step(input bit s, input bit a, input bit b,
                      input logic [31:0] t, input logic [31:0] d);
    applyStimulus(s, a, b, t, d);
    clockModel();
  endtask

  // Assert reset mid-cycle with an ack present, confirm outputs drop at
  // once and nothing is captured across an edge, then release into BOOT.
  task automatic doReset();
    @(negedge clk);
    stall     = 1'b0;
    imem_ack  = 1'b1;
    br_taken  = 1'b0;
    imem_data = 32'hCAFE_F00D;
    reset     = 1'b0;
    #1;
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_if_pc_in", if_pc_in, 32'h0);
    chk("rst_id_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_instr", id_instr, 32'h0);
    modelReset();
    @(posedge clk);
    #1;
    chk("rst_no_capture", {31'h0, id_valid}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("boot_req", {31'h0, imem_req}, 32'h0);
    chk("boot_pc", if_pc_in, 32'h0);
    clockModel();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    stall     = 1'b0;
    imem_ack  = 1'b0;
    imem_data = 32'h0;
    br_taken  = 1'b0;
    br_target = 32'h0;
    modelReset();

    doReset();

    // Streaming fetch with ack tied high, data = addr + 100
    applyStimulus(0, 1, 0, 0, m_pc + 100);
    chk("lit_first_req", {31'h0, imem_req}, 32'h1);
    chk("lit_first_addr", imem_addr, 32'h0);
    clockModel();
    applyStimulus(0, 1, 0, 0, m_pc + 100);
    chk("lit_idpc0", id_pc, 32'h0);
    chk("lit_instr100", id_instr, 32'd100);
    chk("lit_pc1", if_pc_in, 32'h1);
    clockModel();
    applyStimulus(0, 1, 0, 0, m_pc + 100);
    chk("lit_idpc1", id_pc, 32'h1);
    chk("lit_instr101", id_instr, 32'd101);
    clockModel();
    while (!(m_valid && m_idpc == 32'd5)) step(0, 1, 0, 0, m_pc + 100);

    // Decode stalls on instruction 5 for three cycles
    repeat (3) begin
      applyStimulus(1, 1, 0, 0, 32'h7777_7777);
      chk("lit_stall_idpc", id_pc, 32'd5);
      chk("lit_stall_instr", id_instr, 32'd105);
      chk("lit_stall_req", {31'h0, imem_req}, 32'h0);
      chk("lit_stall_pc", if_pc_in, 32'd6);
      clockModel();
    end
    applyStimulus(0, 1, 0, 0, m_pc + 100);
    chk("lit_resume_addr", imem_addr, 32'd6);
    clockModel();
    while (m_pc != 32'd8) step(0, 1, 0, 0, m_pc + 100);

    // Ack held back for three cycles at PC 8
    repeat (3) begin
      applyStimulus(0, 0, 0, 0, 32'h0);
      chk("lit_wait_req", {31'h0, imem_req}, 32'h1);
      chk("lit_wait_addr", imem_addr, 32'd8);
      clockModel();
    end
    applyStimulus(0, 1, 0, 0, 32'd108);
    clockModel();

    // Redirect to 0x40 while the request for PC 9 is outstanding
    applyStimulus(0, 0, 1, 32'h40, 32'h0);
    chk("lit_idpc8", id_pc, 32'd8);
    chk("lit_instr108", id_instr, 32'd108);
    chk("lit_br_addr", imem_addr, 32'd9);
    clockModel();
    repeat (2) begin
      applyStimulus(0, 0, 0, 0, 32'h0);
      chk("lit_flush_addr", imem_addr, 32'd9);
      chk("lit_flush_valid", {31'h0, id_valid}, 32'h0);
      clockModel();
    end
    applyStimulus(0, 1, 0, 0, 32'hDEAD_BEEF);
    chk("lit_flush_ack_addr", imem_addr, 32'd9);
    clockModel();
    applyStimulus(0, 0, 0, 0, 32'h0);
    chk("lit_redirect_addr", imem_addr, 32'h40);
    chk("lit_redirect_valid", {31'h0, id_valid}, 32'h0);
    clockModel();

    // Several redirects while flushing: the last one wins
    applyStimulus(0, 0, 1, 32'h60, 32'h0);
    clockModel();
    applyStimulus(0, 0, 1, 32'h40, 32'h0);
    clockModel();
    applyStimulus(0, 0, 1, 32'h80, 32'h0);
    chk("lit_multi_addr", imem_addr, 32'h40);
    clockModel();
    applyStimulus(0, 1, 0, 0, 32'h5555_5555);
    clockModel();
    applyStimulus(0, 1, 0, 0, m_pc + 100);
    chk("lit_latest_addr", imem_addr, 32'h80);
    chk("lit_latest_valid", {31'h0, id_valid}, 32'h0);
    clockModel();

    // Redirect beats a stall on a held instruction
    applyStimulus(1, 0, 1, 32'h100, 32'h0);
    chk("lit_brst_valid", {31'h0, id_valid}, 32'h1);
    chk("lit_brst_idpc", id_pc, 32'h80);
    clockModel();
    applyStimulus(0, 1, 1, 32'hFFFF_FFFF, 32'h0);
    chk("lit_brst_cleared", {31'h0, id_valid}, 32'h0);
    chk("lit_brst_pc", if_pc_in, 32'h100);
    clockModel();

    // Fetch at the top of the address space wraps the PC to zero
    applyStimulus(0, 1, 0, 0, 32'h1234);
    chk("lit_top_addr", imem_addr, 32'hFFFF_FFFF);
    clockModel();
    applyStimulus(0, 0, 0, 0, 32'h0);
    chk("lit_wrap_pc", if_pc_in, 32'h0);
    chk("lit_wrap_idpc", id_pc, 32'hFFFF_FFFF);
    chk("lit_wrap_instr", id_instr, 32'h1234);
    clockModel();
    step(0, 1, 0, 0, m_pc + 100);
    applyStimulus(0, 0, 0, 0, 32'h0);
    chk("lit_prerst_addr", imem_addr, 32'h1);
    clockModel();

    // Reset while the request for PC 1 is outstanding
    doReset();

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      bit          s;
      bit          a;
      bit          b;
      logic [31:0] t;
      if (i == 1500) doReset();
      s = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 2) != 0);
      b = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFFF - $urandom_range(0, 3);
      else t = $urandom;
      step(s, a, b, t, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  RESET_PC, 32'h0000_0000, PC loaded at reset.
  PC_INC, 32'd1, PC increment per fetched instruction (word addressing).
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk  in  1  sole clock, all state on rising edge.
  reset  in  1  asynchronous, active-low reset.
  imem_req  out  1  instruction-memory request.
  imem_addr  out  32  fetch address; equals PC while imem_req=1.
  imem_ack  in  1  memory response valid; may be same cycle as request.
  imem_data  in  32  instruction word, valid with imem_ack.
  br_taken  in  1  redirect from execute.
  br_target  in  32  redirect PC, valid with br_taken.
  stall  in  1  decode cannot accept the held instruction.
  id_valid  out  1  id_instr/id_pc hold a valid instruction.
  id_instr  out  32  fetched instruction to decode.
  id_pc  out  32  address of id_instr.
  if_pc_in  out  32  current PC, driven to the register file PC write port every cycle.
REQ-003 Clock SHALL be named clk; reset SHALL be named reset, asynchronous, active-low.

Function
REQ-004 States SHALL be BOOT, FETCH, FLUSH; BOOT lasts exactly one cycle after reset release, then FETCH.
REQ-005 slot_free SHALL be !id_valid || !stall; imem_req SHALL be (FETCH && slot_free) || FLUSH; imem_req=0 in BOOT.
REQ-006 Once imem_req rises, imem_req and imem_addr SHALL stay constant until the cycle imem_ack=1 (request stability invariant).
REQ-007 FETCH, imem_ack=1, br_taken=0: next cycle id_instr=imem_data, id_pc=PC, id_valid=1, PC=PC+PC_INC (32-bit wrap, 32'hFFFF_FFFF+1=0).
REQ-008 Decode consumes when id_valid && !stall; if consumed with no new capture, id_valid SHALL clear next cycle.
REQ-009 id_valid && stall with no branch: id_instr/id_pc/id_valid SHALL hold unchanged.
REQ-010 FETCH, br_taken=1, imem_ack=1 (or no request): returned data discarded; next cycle PC=br_target, id_valid=0, state FETCH.
REQ-011 FETCH, br_taken=1, imem_req=1, imem_ack=0: redirect register=br_target, id_valid=0, go FLUSH; PC/imem_addr unchanged.
REQ-012 FLUSH: keep request; on imem_ack discard data, PC=redirect register, go FETCH; br_taken in FLUSH overwrites redirect register (latest wins).
REQ-013 br_taken SHALL take priority over stall and capture; id_valid cleared the next cycle in every state.
REQ-014 if_pc_in SHALL equal the PC register combinationally; latency request-to-id_valid = 1 cycle after imem_ack.

Reset
REQ-015 On reset=0, immediately: PC=RESET_PC, state=BOOT, id_valid=0, id_instr=0, id_pc=0, redirect=0, imem_req=0, imem_addr=RESET_PC, if_pc_in=RESET_PC.
REQ-016 Reset mid-request SHALL abandon the request; no capture of a concurrent imem_ack.

Structure
REQ-017 State encoding, RESET_PC default and 32-bit word width SHALL live in shared package pika_pkg.
REQ-018 No sub-module; single flat module.

Verification
REQ-019 Reset release, imem_ack tied 1, data=addr+100, stall=0 -> cycle after BOOT id_valid=1, id_pc=0,1,2..., id_instr=100,101,...; if_pc_in tracks PC.
REQ-020 stall=1 three cycles while id_valid, id_pc=5 -> id_* unchanged, imem_req=0, PC=6; stall drops -> fetch of 6 resumes.
REQ-021 imem_ack delayed 3 cycles at PC=8 -> imem_req/imem_addr=8 stable all 3 cycles, id_pc=8 one cycle after ack.
REQ-022 br_taken, br_target=32'h40 during pending request at PC=9 -> FLUSH, addr stays 9 until ack, data discarded, next fetch addr 32'h40, id_valid=0 throughout.
REQ-023 Two branches in FLUSH (0x40 then 0x80) -> next fetch addr 0x80; br_taken with stall=1 -> id_valid=0 next cycle.
REQ-024 PC=32'hFFFF_FFFF fetch -> PC wraps to 0; reset=0 asserted mid-request -> outputs at REQ-015 values without waiting for clk.
